// File: rtl/knn_vote.sv
// ---------------------------------------------------------------------------
// knn_vote -- majority-vote classifier for one KNN test point.
//
// Takes the packed neighbour-label vector of one test point (slot 0 = nearest
// neighbour), builds a per-class histogram one slot per cycle, then scans the
// histogram one class per cycle. It returns the winning class and its vote
// count through a valid/ready handshake.
//
// Build option: define KNN_VOTE_NEAREST_TIE_EN to break equal-count ties in
// favour of the class whose first vote came from the nearer neighbour.
// Without it, ties go to the lowest class index and no per-class slot index
// storage is built. Latency is the same in both builds.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid and its data stable
// until that edge. in_ready is 1 only in IDLE. out_valid is 1 only in DONE,
// and class_out/votes_out/tie/bad_label stay stable until the transfer.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   clear          synchronous abort back to IDLE (beats in_valid/out_ready)
//   in_valid       neighbour_info valid
//   in_ready       block can accept a vector (IDLE)
//   neighbour_info packed labels, slot j at [(j+1)*LABEL_W-1 : j*LABEL_W]
//   out_valid      result valid (DONE)
//   out_ready      consumer takes the result
//   class_out      winning class
//   votes_out      vote count of the winning class
//   tie            another class shared the maximum count
//   bad_label      at least one label was >= N_CLASSES
//   busy           state is not IDLE
//   state_dbg      current FSM state (0 IDLE, 1 COUNT, 2 SCAN, 3 DONE)
// ---------------------------------------------------------------------------
module knn_vote #(
  parameter int LABEL_W     = 8,
  parameter int N_NEIGHBOUR = 10,
  parameter int N_CLASSES   = 16,
  parameter int CNT_W       = $clog2(N_NEIGHBOUR + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_NEIGHBOUR*LABEL_W-1:0] neighbour_info,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LABEL_W-1:0]             class_out,
  output logic [CNT_W-1:0]               votes_out,
  output logic                           tie,
  output logic                           bad_label,
  output logic                           busy,
  output logic [1:0]                     state_dbg
);

  localparam int NB_W  = (N_NEIGHBOUR > 1) ? $clog2(N_NEIGHBOUR) : 1;
  localparam int CLS_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [NB_W-1:0]  LAST_NB  = NB_W'(N_NEIGHBOUR - 1);
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(N_CLASSES - 1);
  localparam logic [31:0]      NCLS_U   = 32'(N_CLASSES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                         state;
  logic [N_NEIGHBOUR*LABEL_W-1:0] vec;
  logic [CNT_W-1:0]               hist [N_CLASSES];
  logic [NB_W-1:0]                nb_idx;
  logic [CLS_W-1:0]               cls_idx;
  logic [CLS_W-1:0]               best;
  logic [CNT_W-1:0]               best_cnt;
  logic                           tie_int;
  logic                           bad_label_int;

`ifdef KNN_VOTE_NEAREST_TIE_EN
  logic [NB_W-1:0]                first_idx [N_CLASSES];
  logic [NB_W-1:0]                best_first;
  logic [NB_W-1:0]                nxt_first;
`endif

  // Label of the slot being counted this cycle.
  logic [LABEL_W-1:0] slot_lbl;
  logic               slot_legal;
  logic [CLS_W-1:0]   slot_cls;

  always_comb begin
    slot_lbl   = vec[int'(nb_idx)*LABEL_W +: LABEL_W];
    slot_legal = (32'(slot_lbl) < NCLS_U);
    slot_cls   = slot_lbl[CLS_W-1:0];
  end

  // One scan step: fold hist[cls_idx] into the running best. The final step's
  // result is registered straight into the outputs, so it is computed here.
  logic [CNT_W-1:0] cur_cnt;
  logic [CLS_W-1:0] nxt_best;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_tie;

  always_comb begin
    cur_cnt  = hist[cls_idx];
    nxt_best = best;
    nxt_cnt  = best_cnt;
    nxt_tie  = tie_int;
`ifdef KNN_VOTE_NEAREST_TIE_EN
    nxt_first = best_first;
`endif
    if (cur_cnt > best_cnt) begin
      nxt_best = cls_idx;
      nxt_cnt  = cur_cnt;
      nxt_tie  = 1'b0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
      nxt_first = first_idx[cls_idx];
`endif
    end else if ((cur_cnt == best_cnt) && (cur_cnt != '0)) begin
      nxt_tie = 1'b1;
`ifdef KNN_VOTE_NEAREST_TIE_EN
      // Equal count: the class first voted by the nearer slot wins.
      if (first_idx[cls_idx] < best_first) begin
        nxt_best  = cls_idx;
        nxt_first = first_idx[cls_idx];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      vec           <= '0;
      nb_idx        <= '0;
      cls_idx       <= '0;
      best          <= '0;
      best_cnt      <= '0;
      tie_int       <= 1'b0;
      bad_label_int <= 1'b0;
      for (int c = 0; c < N_CLASSES; c++) hist[c] <= '0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
      for (int c = 0; c < N_CLASSES; c++) first_idx[c] <= '0;
      best_first    <= '0;
`endif
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      class_out     <= '0;
      votes_out     <= '0;
      tie           <= 1'b0;
      bad_label     <= 1'b0;
    end else if (clear) begin
      // Abort: control returns to IDLE, result registers keep their values.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec           <= neighbour_info;
            nb_idx        <= '0;
            bad_label_int <= 1'b0;
            for (int c = 0; c < N_CLASSES; c++) hist[c] <= '0;
            state         <= COUNT;
            in_ready      <= 1'b0;
            busy          <= 1'b1;
          end
        end

        COUNT: begin
          if (slot_legal) begin
            hist[slot_cls] <= hist[slot_cls] + CNT_W'(1);
`ifdef KNN_VOTE_NEAREST_TIE_EN
            if (hist[slot_cls] == '0) first_idx[slot_cls] <= nb_idx;
`endif
          end else begin
            bad_label_int <= 1'b1;
          end
          if (nb_idx == LAST_NB) begin
            cls_idx  <= '0;
            best     <= '0;
            best_cnt <= '0;
            tie_int  <= 1'b0;
`ifdef KNN_VOTE_NEAREST_TIE_EN
            best_first <= '0;
`endif
            state    <= SCAN;
          end else begin
            nb_idx <= nb_idx + NB_W'(1);
          end
        end

        SCAN: begin
          best     <= nxt_best;
          best_cnt <= nxt_cnt;
          tie_int  <= nxt_tie;
`ifdef KNN_VOTE_NEAREST_TIE_EN
          best_first <= nxt_first;
`endif
          if (cls_idx == LAST_CLS) begin
            class_out <= LABEL_W'(nxt_best);
            votes_out <= nxt_cnt;
            tie       <= nxt_tie;
            bad_label <= bad_label_int;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cls_idx <= cls_idx + CLS_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Downstream classification stage of the KNN accelerator.
- Consumes the packed neighbour-label vector that one knn_core produces for one test point. Slot 0 is the nearest neighbour.
- Builds a per-class histogram one neighbour per cycle, then scans the histogram one class per cycle.
- Returns the majority class and its vote count through a valid/ready handshake. One instance per test point; results are read back through the software register file.

Parameters:
- LABEL_W, 8, width of one label field (matches `LABEL).
- N_NEIGHBOUR, 10, neighbours per test point (matches `N_Neighbour).
- N_CLASSES, 16, number of legal classes; legal labels are 0..N_CLASSES-1.
- CNT_W, $clog2(N_NEIGHBOUR+1), width of the vote counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  neighbour_info is valid.
- in_ready  out  1  block can accept a vector.
- neighbour_info  in  N_NEIGHBOUR*LABEL_W  packed labels; slot j occupies [(j+1)*LABEL_W-1 : j*LABEL_W].
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- class_out  out  LABEL_W  winning class.
- votes_out  out  CNT_W  vote count of the winning class.
- tie  out  1  another class had the same maximum count.
- bad_label  out  1  at least one label was >= N_CLASSES.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except in_ready, which is 1. Histogram, index counters and the captured vector are cleared.
- States: IDLE -> COUNT -> SCAN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: capture neighbour_info, zero all N_CLASSES counters, set neighbour index=0, go to COUNT.
- COUNT:
  - Lasts N_NEIGHBOUR cycles, one slot per cycle, index 0..N_NEIGHBOUR-1.
  - Slot label L < N_CLASSES: hist[L] += 1.
  - Otherwise: no count; set the sticky bad_label_int.
  - After slot N_NEIGHBOUR-1: class index=0, best=0, best_cnt=0, tie_int=0, go to SCAN.
- SCAN:
  - Lasts N_CLASSES cycles, one class c per cycle.
  - hist[c] > best_cnt: best=c, best_cnt=hist[c], tie_int=0.
  - hist[c] == best_cnt and hist[c] != 0: tie_int=1; best is unchanged, so the lowest index wins.
  - After class N_CLASSES-1: register class_out, votes_out, tie and bad_label; go to DONE.
- DONE:
  - out_valid=1. Outputs are held stable until out_ready=1.
  - On out_ready=1: out_valid drops on the next edge and the state returns to IDLE.
  - in_ready is 0 in every state except IDLE, so there is no overlap between vectors.
- Latency: if a vector is accepted on clock edge E, out_valid rises on edge E+N_NEIGHBOUR+N_CLASSES.
- Throughput: one result per N_NEIGHBOUR+N_CLASSES+2 cycles when out_ready is held at 1.
- All labels illegal: votes_out=0, class_out=0, tie=0, bad_label=1.
- Counter arithmetic: counters saturate-free. CNT_W is sized so that N_NEIGHBOUR votes for one class cannot overflow.
- clear=1:
  - Applies in any state: state goes to IDLE and out_valid is forced to 0 on the next edge.
  - clear takes priority over in_valid and out_ready in the same cycle.
  - The output data registers keep their old values.
- Reset asserted mid-operation: immediate return to reset values; no partial result is emitted.
- in_valid while busy: ignored (in_ready=0); the upstream stage must hold it.

Optional Feature:
- Macro: KNN_VOTE_NEAREST_TIE_EN.
- Defined:
  - A per-class register first_idx[c] (width $clog2(N_NEIGHBOUR)) records the slot index of the first vote for c during COUNT.
  - In SCAN, on equal counts the class with the smaller first_idx wins, i.e. the class of the nearer neighbour.
  - tie is still set whenever the maximum count is shared.
- Undefined: ties resolve to the lowest class index and no first_idx storage exists.
- Latency is identical in both builds.

Test Plan:
Bench parameters: LABEL_W=4, N_NEIGHBOUR=5, N_CLASSES=4. Slots are listed in order 0..4.
- Reset then idle: rst low for 3 cycles, released -> in_ready=1, out_valid=0, class_out=0, votes_out=0, busy=0.
- Clear majority: labels {2,1,2,3,2} -> out_valid exactly 9 edges after accept; class_out=2, votes_out=3, tie=0, bad_label=0.
- Tie:
  - Labels {3,1,1,3,0} -> tie=1, votes_out=2.
  - Macro undefined: class_out=1.
  - Macro defined: class_out=3.
- Illegal labels: {7,7,1,9,0} -> class_out=0, votes_out=1, tie=1, bad_label=1. Labels {15,15,15,15,15} -> class_out=0, votes_out=0, bad_label=1.
- Backpressure and chaining:
  - Hold out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is not accepted.
  - Raise out_ready -> back to IDLE; the second vector is accepted next cycle and produces its own correct result.
- Abort: assert clear during COUNT slot 2, then during SCAN, then async rst low during DONE -> out_valid=0 and busy=0 after each. A following vector {0,0,0,0,0} yields class_out=0, votes_out=5.
